// File: rtl/fb_sram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fb_pkg                                                           |
// | Purpose : Shared types and constants for the frame-buffer SRAM arbiter.    |
// |           Arbiter state encoding, default bus widths, last pixel address,  |
// |           and a helper telling whether a state may start a new access.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fb_pkg;

  localparam int unsigned              FB_ADDR_W    = 20;
  localparam int unsigned              FB_DATA_W    = 16;
  // Last word of a 640x480 frame (0x4B000 words).
  localparam logic [FB_ADDR_W-1:0]     FB_LAST_ADDR = 20'h4AFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  // A new read or write may only be launched while the bus is not owned by a
  // write or its turnaround cycle.
  function automatic logic fb_can_launch(input arb_state_t s);
    return (s == IDLE) || (s == READ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rd_pending.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_rd_pending                                                    |
// | Purpose : One-entry read-address buffer used while a write owns the bus.   |
// |           A push into a full, non-draining buffer is dropped and raises a  |
// |           sticky overrun flag (cleared only by reset).                     |
// | Ports   : clk, n_rst        clock / async active-low reset                 |
// |           i_push, i_push_addr  store a read address                        |
// |           i_drain          the held entry is consumed this cycle           |
// |           o_full, o_addr   buffer state / held address                     |
// |           o_overrun        sticky drop indicator                           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_rd_pending
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic              i_drain,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_overrun
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overrun;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
    end else if (i_drain) begin
      // A push coinciding with a drain refills the slot just vacated.
      r_full <= i_push;
      if (i_push) begin
        r_addr <= i_push_addr;
      end
    end else if (i_push) begin
      if (r_full) begin
        r_overrun <= 1'b1;
      end else begin
        r_full <= 1'b1;
        r_addr <= i_push_addr;
      end
    end
  end

  assign o_full    = r_full;
  assign o_addr    = r_addr;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/fb_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fb_sram_arbiter                                                  |
// | Purpose : Shares the single-port frame-buffer SRAM between the display     |
// |           pixel-fetch reads (priority) and the image-writer port. Writes   |
// |           fill read gaps; one read is buffered while a write finishes.     |
// | Ports   : clk, n_rst                        clock / async active-low reset |
// |           rd_req, rd_addr                   display read request           |
// |           rd_data, rd_valid, rd_overrun     read return / sticky drop flag |
// |           wr_req, wr_addr, wr_data, wr_ack  writer handshake               |
// |           sram_addr, sram_wdata, sram_rdata SRAM address / data            |
// |           sram_oe_n, sram_we_n, sram_drv    SRAM strobes / bus drive       |
// | Options : FB_ARB_STARVE_GUARD_EN - force a write after WR_MAX_WAIT cycles  |
// |           of waiting, even against a read request.                         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fb_sram_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned DATA_W      = FB_DATA_W,
  parameter int unsigned WR_MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_overrun,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_drv
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_drv;
  logic              r_wr_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_p_full;
  logic [ADDR_W-1:0] w_p_addr;
  logic              w_p_overrun;
  logic              w_launch_ok;
  logic              w_force;
  logic              w_grant;
  logic              w_drain;
  logic              w_rd_direct;
  logic              w_push;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;

  assign w_launch_ok = fb_can_launch(r_state);

  // Writes only take the bus when no read wants it, unless the starvation
  // guard forces the grant; a forced grant still waits for an empty buffer so
  // the displaced read has somewhere to go.
  assign w_grant     = w_launch_ok && wr_req && !w_p_full && (!rd_req || w_force);
  assign w_drain     = w_launch_ok && w_p_full;
  assign w_rd_direct = w_launch_ok && !w_p_full && rd_req && !w_grant;
  // Any read that cannot go straight to the bus lands in the buffer.
  assign w_push       = rd_req && !w_rd_direct;
  assign w_issue      = w_drain || w_rd_direct;
  assign w_issue_addr = w_drain ? w_p_addr : rd_addr;

  fb_rd_pending #(
    .ADDR_W (ADDR_W)
  ) u_pending (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_push),
    .i_push_addr (rd_addr),
    .i_drain     (w_drain),
    .o_full      (w_p_full),
    .o_addr      (w_p_addr),
    .o_overrun   (w_p_overrun)
  );

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int unsigned           C_WAIT_W   = $clog2(WR_MAX_WAIT + 1);
  localparam logic [C_WAIT_W-1:0]   C_WAIT_MAX = C_WAIT_W'(WR_MAX_WAIT);

  logic [C_WAIT_W-1:0] r_wait;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wait <= '0;
    end else if (r_wr_ack) begin
      r_wait <= '0;
    end else if (wr_req && !w_grant && (r_wait != C_WAIT_MAX)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_force = (r_wait == C_WAIT_MAX);
`else
  logic w_unused_guard;
  assign w_unused_guard = (WR_MAX_WAIT == 0);
  assign w_force        = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, READ: begin
        if (w_grant) begin
          w_next = WRITE;
        end else if (w_issue) begin
          w_next = READ;
        end else begin
          w_next = IDLE;
        end
      end
      // The bus always gets one undriven cycle after a write.
      WRITE:   w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_drv        <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_oe_n   <= (w_next != READ);
      r_we_n   <= (w_next != WRITE);
      r_drv    <= (w_next == WRITE);
      r_wr_ack <= (w_next == WRITE);
      if (w_next == WRITE) begin
        r_sram_addr  <= wr_addr;
        r_sram_wdata <= wr_data;
      end else if (w_issue) begin
        r_sram_addr <= w_issue_addr;
      end
      // SRAM data is valid at the end of the cycle its address was presented.
      r_rd_valid <= (r_state == READ);
      if (r_state == READ) begin
        r_rd_data <= sram_rdata;
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign rd_overrun = w_p_overrun;
  assign wr_ack     = r_wr_ack;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_drv   = r_drv;

endmodule
`default_nettype wire
